// File: rtl/kirsch_pkg.sv
// Shared types and defaults for the Kirsch window generator and kernel stages.
package kirsch_pkg;

   localparam int PIX_W          = 8;
   localparam int DEF_IMG_WIDTH  = 64;
   localparam int DEF_IMG_HEIGHT = 64;

   typedef logic [PIX_W-1:0] pixel_t;

   // Index 0 is p1 (top-left), index 8 is p9 (bottom-right), row-major.
   typedef pixel_t window_t [0:8];

endpackage

// File: rtl/kirsch_line_buf.sv
// Enable-gated delay line: dout is the pixel written DEPTH enabled cycles earlier.
module kirsch_line_buf
   import kirsch_pkg::*;
#(
   parameter int DEPTH = DEF_IMG_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic [PIX_W-1:0] din,
   output logic [PIX_W-1:0] dout
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   pixel_t          mem [DEPTH];
   logic [AW-1:0]   ptr;

   // NOTE: sequential state is always assigned with <= so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ptr <= '0;
      end else if (en) begin
         ptr <= (ptr == AW'(DEPTH - 1)) ? '0 : ptr + 1'b1;
      end
   end

   // NOTE: the storage array is deliberately not reset so it maps onto plain RAM.
   always_ff @(posedge clk) begin
      if (en) begin
         mem[ptr] <= din;
      end
   end

   // Read-before-write at the same slot yields the oldest stored pixel.
   assign dout = mem[ptr];

endmodule

// File: rtl/kirsch_window_gen.sv
// 3x3 window generator for the Kirsch datapath; define KIRSCH_WIN_COORD_EN to add win_cx/win_cy.
module kirsch_window_gen
   import kirsch_pkg::*;
#(
   parameter int IMG_WIDTH  = DEF_IMG_WIDTH,
   parameter int IMG_HEIGHT = DEF_IMG_HEIGHT
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [PIX_W-1:0] pix_in,
   input  logic             pix_valid,
   input  logic             pix_sof,
   output logic [PIX_W-1:0] p1,
   output logic [PIX_W-1:0] p2,
   output logic [PIX_W-1:0] p3,
   output logic [PIX_W-1:0] p4,
   output logic [PIX_W-1:0] p5,
   output logic [PIX_W-1:0] p6,
   output logic [PIX_W-1:0] p7,
   output logic [PIX_W-1:0] p8,
   output logic [PIX_W-1:0] p9,
   output logic             win_valid,
   output logic             frame_done
`ifdef KIRSCH_WIN_COORD_EN
   ,
   output logic [$clog2(IMG_WIDTH)-1:0]  win_cx,
   output logic [$clog2(IMG_HEIGHT)-1:0] win_cy
`endif
);

   localparam int CW = $clog2(IMG_WIDTH);
   localparam int RW = $clog2(IMG_HEIGHT);

   logic [CW-1:0] col, pos_c, nxt_col;
   logic [RW-1:0] row, pos_r, nxt_row;
   logic          last_c, last_r, win_hit;
   pixel_t        lb0_out, lb1_out;
   window_t       win;
   logic          pend_valid, pend_done;
`ifdef KIRSCH_WIN_COORD_EN
   logic [CW-1:0] pend_cx;
   logic [RW-1:0] pend_cy;
`endif

   // Position of the pixel being accepted; sof forces it to the frame origin.
   // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
   always_comb begin
      pos_c   = pix_sof ? '0 : col;
      pos_r   = pix_sof ? '0 : row;
      last_c  = (pos_c == CW'(IMG_WIDTH - 1));
      last_r  = (pos_r == RW'(IMG_HEIGHT - 1));
      nxt_col = last_c ? '0 : pos_c + 1'b1;
      nxt_row = pos_r;
      if (last_c) begin
         nxt_row = last_r ? '0 : pos_r + 1'b1;
      end
      win_hit = (pos_c >= CW'(2)) && (pos_r >= RW'(2));
   end

   kirsch_line_buf #(.DEPTH(IMG_WIDTH)) u_lb0 (
      .clk  (clk),
      .rst_n(rst_n),
      .en   (pix_valid),
      .din  (pix_in),
      .dout (lb0_out)
   );

   kirsch_line_buf #(.DEPTH(IMG_WIDTH)) u_lb1 (
      .clk  (clk),
      .rst_n(rst_n),
      .en   (pix_valid),
      .din  (lb0_out),
      .dout (lb1_out)
   );

   // Stage 1: counters and window shift register advance on accepted pixels.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         col        <= '0;
         row        <= '0;
         pend_valid <= 1'b0;
         pend_done  <= 1'b0;
         for (int i = 0; i < 9; i++) begin
            win[i] <= '0;
         end
      end else begin
         pend_valid <= pix_valid && win_hit;
         pend_done  <= pix_valid && last_c && last_r;
         if (pix_valid) begin
            col <= nxt_col;
            row <= nxt_row;
            for (int r = 0; r < 3; r++) begin
               win[3*r]     <= win[3*r + 1];
               win[3*r + 1] <= win[3*r + 2];
            end
            win[2] <= lb1_out;
            win[5] <= lb0_out;
            win[8] <= pix_in;
         end
      end
   end

`ifdef KIRSCH_WIN_COORD_EN
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pend_cx <= '0;
         pend_cy <= '0;
      end else if (pix_valid && win_hit) begin
         pend_cx <= pos_c - 1'b1;
         pend_cy <= pos_r - 1'b1;
      end
   end
`endif

   // Stage 2: registered outputs hold the last complete window between pulses.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         win_valid  <= 1'b0;
         frame_done <= 1'b0;
         p1 <= '0; p2 <= '0; p3 <= '0;
         p4 <= '0; p5 <= '0; p6 <= '0;
         p7 <= '0; p8 <= '0; p9 <= '0;
`ifdef KIRSCH_WIN_COORD_EN
         win_cx <= '0;
         win_cy <= '0;
`endif
      end else begin
         win_valid  <= pend_valid;
         frame_done <= pend_done;
         if (pend_valid) begin
            p1 <= win[0]; p2 <= win[1]; p3 <= win[2];
            p4 <= win[3]; p5 <= win[4]; p6 <= win[5];
            p7 <= win[6]; p8 <= win[7]; p9 <= win[8];
`ifdef KIRSCH_WIN_COORD_EN
            win_cx <= pend_cx;
            win_cy <= pend_cy;
`endif
         end
      end
   end

endmodule

// File: tb/tb_kirsch_window_gen.sv
// Self-checking bench for kirsch_window_gen (4x4 image); coordinate checks when KIRSCH_WIN_COORD_EN is defined.
module tb_kirsch_window_gen;

   localparam int W = 4;
   localparam int H = 4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       pix_valid = 1'b0;
   logic       pix_sof = 1'b0;
   logic [7:0] pix_in = '0;
   logic [7:0] p1, p2, p3, p4, p5, p6, p7, p8, p9;
   logic       win_valid, frame_done;
`ifdef KIRSCH_WIN_COORD_EN
   logic [1:0] win_cx, win_cy;
`endif

   always #5 clk = ~clk;

   kirsch_window_gen #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .pix_in    (pix_in),
      .pix_valid (pix_valid),
      .pix_sof   (pix_sof),
      .p1(p1), .p2(p2), .p3(p3),
      .p4(p4), .p5(p5), .p6(p6),
      .p7(p7), .p8(p8), .p9(p9),
      .win_valid (win_valid),
      .frame_done(frame_done)
`ifdef KIRSCH_WIN_COORD_EN
      ,
      .win_cx    (win_cx),
      .win_cy    (win_cy)
`endif
   );

   typedef struct {
      logic        wv;
      logic        fd;
      logic [71:0] pv;
      int          cx;
      int          cy;
   } exp_t;

   typedef struct {
      logic       v;
      logic       s;
      logic [7:0] px;
      logic       ewv;
      logic       efd;
      logic [7:0] ep9;
   } vec_t;

   int         n_cmp = 0;
   int         n_err = 0;
   int         n_win = 0;
   int         n_done = 0;
   int         k = 0;
   logic [7:0] img [H][W];
   exp_t       cur, pend;
   vec_t       tbl [18];

   task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference: frame index k addresses a 2-D image; a window is the 3x3 block ending at (r,c).
   task automatic step(input logic rst, input logic v, input logic s, input logic [7:0] px);
      exp_t nxt, np;
      int   r, c;
      rst_n     = rst;
      pix_valid = v;
      pix_sof   = s;
      pix_in    = px;
      np = '{wv: 1'b0, fd: 1'b0, pv: '0, cx: 0, cy: 0};
      if (!rst) begin
         nxt = np;
         k   = 0;
      end else begin
         nxt    = cur;
         nxt.wv = 1'b0;
         nxt.fd = 1'b0;
         if (pend.wv) nxt = pend;
         if (v) begin
            if (s) k = 0;
            r = k / W;
            c = k % W;
            img[r][c] = px;
            if (r >= 2 && c >= 2) begin
               np.wv = 1'b1;
               np.fd = (k == W*H - 1);
               np.cx = c - 1;
               np.cy = r - 1;
               np.pv = {img[r-2][c-2], img[r-2][c-1], img[r-2][c],
                        img[r-1][c-2], img[r-1][c-1], img[r-1][c],
                        img[r][c-2],   img[r][c-1],   img[r][c]};
            end
            k = (k + 1) % (W*H);
         end
      end
      @(posedge clk);
      @(negedge clk);
      check("win_valid", 72'(win_valid), 72'(nxt.wv));
      check("frame_done", 72'(frame_done), 72'(nxt.fd));
      check("window", {p1, p2, p3, p4, p5, p6, p7, p8, p9}, nxt.pv);
`ifdef KIRSCH_WIN_COORD_EN
      check("coord", 72'({win_cx, win_cy}), 72'({2'(nxt.cx), 2'(nxt.cy)}));
`endif
      if (win_valid === 1'b1) n_win++;
      if (frame_done === 1'b1) n_done++;
      cur  = nxt;
      pend = np;
   endtask

   task automatic send_frame(input int npix, input logic with_sof);
      for (int i = 0; i < npix; i++) begin
         step(1'b1, 1'b1, with_sof && (i == 0), 8'(i));
      end
   endtask

   task automatic clear_counts();
      n_win  = 0;
      n_done = 0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      cur  = '{wv: 1'b0, fd: 1'b0, pv: '0, cx: 0, cy: 0};
      pend = cur;

      // 4x4 ramp vectors: pixel i = 4r+c, sof on the first pixel, two idle flush cycles.
      for (int i = 0; i < 18; i++) begin
         tbl[i] = '{v: (i < 16), s: (i == 0), px: 8'(i), ewv: 1'b0, efd: 1'b0, ep9: 8'd0};
      end
      tbl[11].ewv = 1'b1; tbl[11].ep9 = 8'd10;
      tbl[12].ewv = 1'b1; tbl[12].ep9 = 8'd11;
      tbl[15].ewv = 1'b1; tbl[15].ep9 = 8'd14;
      tbl[16].ewv = 1'b1; tbl[16].ep9 = 8'd15; tbl[16].efd = 1'b1;

      @(negedge clk);
      step(1'b0, 1'b0, 1'b0, 8'd0);
      check("reset_outputs", {p1, p2, p3, p4, p5, p6, p7, p8, p9}, 72'd0);
      step(1'b0, 1'b1, 1'b1, 8'd77);
      step(1'b1, 1'b0, 1'b0, 8'd0);

      clear_counts();
      for (int i = 0; i < 18; i++) begin
         step(1'b1, tbl[i].v, tbl[i].s, tbl[i].px);
         check("tbl_wv", 72'(win_valid), 72'(tbl[i].ewv));
         check("tbl_fd", 72'(frame_done), 72'(tbl[i].efd));
         if (tbl[i].ewv) check("tbl_p9", 72'(p9), 72'(tbl[i].ep9));
         if (i == 11) check("first_window", {p1, p2, p3, p4, p5, p6, p7, p8, p9},
                            72'h00_01_02_04_05_06_08_09_0A);
      end
      check("ramp_wins", 72'(n_win), 72'd4);

      // Gapped input with garbage on pix_in during gaps.
      clear_counts();
      begin
         int idx = 0;
         for (int n = 0; n < 400 && idx < 16; n++) begin
            logic v;
            v = 1'($urandom_range(0, 1));
            step(1'b1, v, v && (idx == 0), v ? 8'(idx) : 8'($urandom));
            if (v) idx++;
         end
         check("gap_all_sent", 72'(idx), 72'd16);
      end
      step(1'b1, 1'b0, 1'b0, 8'd0);
      step(1'b1, 1'b0, 1'b0, 8'd0);
      check("gap_wins", 72'(n_win), 72'd4);
      check("gap_done", 72'(n_done), 72'd1);

      // Back-to-back frames, sof on the natural wrap.
      clear_counts();
      send_frame(16, 1'b1);
      send_frame(16, 1'b1);
      step(1'b1, 1'b0, 1'b0, 8'd0);
      step(1'b1, 1'b0, 1'b0, 8'd0);
      check("b2b_wins", 72'(n_win), 72'd8);
      check("b2b_done", 72'(n_done), 72'd2);

      // Reset while accepting row 2, col 1; next frame starts without sof.
      send_frame(9, 1'b1);
      step(1'b0, 1'b1, 1'b0, 8'd9);
      check("midrst_zero", {win_valid, frame_done, p1, p2, p3, p4, p5, p6, p7, p8, p9}, 72'd0);
      clear_counts();
      send_frame(16, 1'b0);
      step(1'b1, 1'b0, 1'b0, 8'd0);
      step(1'b1, 1'b0, 1'b0, 8'd0);
      check("midrst_wins", 72'(n_win), 72'd4);
      check("midrst_done", 72'(n_done), 72'd1);

      // sof reasserted at row 2, col 0 abandons the partial frame.
      clear_counts();
      send_frame(8, 1'b1);
      check("midsof_no_done", 72'(n_done), 72'd0);
      send_frame(16, 1'b1);
      step(1'b1, 1'b0, 1'b0, 8'd0);
      step(1'b1, 1'b0, 1'b0, 8'd0);
      check("midsof_wins", 72'(n_win), 72'd4);
      check("midsof_done", 72'(n_done), 72'd1);

      // Random pixels, random gaps, occasional random sof.
      for (int n = 0; n < 400; n++) begin
         logic v, s;
         v = ($urandom_range(0, 3) != 0);
         s = v && ($urandom_range(0, 39) == 0);
         step(1'b1, v, s, 8'($urandom));
      end
      step(1'b1, 1'b0, 1'b0, 8'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
